// File: rtl/register_file_ctx_pkg.sv
// Shared definitions for the register file / interrupt-context slice of the
// SimpleRISC core: flag layout, default special-register indices and the
// context FSM state type.
package register_file_ctx_pkg;

  // Flag layout: bit 0 = E (equal), bit 1 = GT (greater-than)
  localparam int PKG_FLAG_W = 2;
  localparam int FLAG_E     = 0;
  localparam int FLAG_GT    = 1;

  // Architectural indices with special meaning
  localparam int DEF_FLAGS_IDX = 13;
  localparam int DEF_EPC_IDX   = 12;
  localparam int DEF_SP_IDX    = 14;
  localparam int DEF_SP_RESET  = 20;

  typedef enum logic {
    IDLE = 1'b0,
    ISR  = 1'b1
  } ctx_state_e;

endpackage

// File: rtl/register_file_ctx_if.sv
// Operand-fetch / writeback / interrupt bus of the register file.
//   master : the core side (drives addresses, write data, flags, pc, irq)
//   slave  : the register file (returns read data, flags, irq status)
interface register_file_ctx_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int FLAG_W = 2
);
  localparam int AW = $clog2(NREGS);

  logic              isWb;
  logic [AW-1:0]     rd_ra;
  logic [DATA_W-1:0] data;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              flags_we;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flags_out;
  logic [DATA_W-1:0] pc;
  logic              interrupt;
  logic              ret_i;
  logic              irq_ack;
  logic              in_isr;

  modport master (
    output isWb, rd_ra, data, rs1, rs2, flags_we, flags_in, pc, interrupt, ret_i,
    input  rd1, rd2, flags_out, irq_ack, in_isr
  );

  modport slave (
    input  isWb, rd_ra, data, rs1, rs2, flags_we, flags_in, pc, interrupt, ret_i,
    output rd1, rd2, flags_out, irq_ack, in_isr
  );

endinterface

// File: rtl/register_file_ctx_irq_ctx_fsm.sv
// irq_ctx_fsm: interrupt context controller.
// Detects the rising edge of the level interrupt request, keeps a single-deep
// pending bit while an ISR runs, and issues capture (entry) / restore (return)
// strobes to the register array.
//   clk, rst   : clock, asynchronous active-high reset
//   interrupt  : level interrupt request
//   ret_i      : return-from-interrupt strobe
//   capture    : combinational, high in the cycle whose clock edge enters ISR
//   restore    : combinational, high in the cycle whose clock edge leaves ISR
//   irq_ack    : registered one-cycle pulse following entry
//   in_isr     : high while in the ISR state
module irq_ctx_fsm
  import register_file_ctx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic interrupt,
  input  logic ret_i,
  output logic capture,
  output logic restore,
  output logic irq_ack,
  output logic in_isr
);

  ctx_state_e state;
  ctx_state_e state_next;
  logic       irq_q;
  logic       irq_pend;
  logic       pend_next;
  logic       irq_edge;

  assign irq_edge = interrupt & ~irq_q;
  assign in_isr   = (state == ISR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      irq_q    <= 1'b0;
      irq_pend <= 1'b0;
      irq_ack  <= 1'b0;
    end else begin
      state    <= state_next;
      irq_q    <= interrupt;
      irq_pend <= pend_next;
      irq_ack  <= capture;
    end
  end

  always_comb begin
    state_next = state;
    pend_next  = irq_pend;
    capture    = 1'b0;
    restore    = 1'b0;
    case (state)
      IDLE: begin
        // A request left pending by the previous ISR is taken here, on the
        // first IDLE cycle after the return. ret_i is ignored in IDLE.
        if (irq_edge || irq_pend) begin
          capture    = 1'b1;
          pend_next  = 1'b0;
          state_next = ISR;
        end
      end
      ISR: begin
        // Single-deep: an edge while already pending is simply dropped
        if (irq_edge) pend_next = 1'b1;
        if (ret_i) begin
          restore    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/register_file_ctx.sv
// register_file_ctx: NREGS x DATA_W register file with two combinational
// read ports, one synchronous write port and optional write-to-read bypass,
// plus a flags register and an interrupt-context unit that saves PC (into
// EPC_IDX) and flags on interrupt entry and restores flags on return.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : register_file_ctx_if.slave (read/write ports, flags, pc,
//          interrupt, ret_i, irq_ack, in_isr)
module register_file_ctx
  import register_file_ctx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 16,
  parameter int FLAG_W    = PKG_FLAG_W,
  parameter int FLAGS_IDX = DEF_FLAGS_IDX,
  parameter int EPC_IDX   = DEF_EPC_IDX,
  parameter int SP_IDX    = DEF_SP_IDX,
  parameter int SP_RESET  = DEF_SP_RESET,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  register_file_ctx_if.slave bus
);

  localparam int            AW      = $clog2(NREGS);
  localparam logic [AW-1:0] FLAGS_A = AW'(FLAGS_IDX);
  localparam logic [AW-1:0] EPC_A   = AW'(EPC_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [FLAG_W-1:0] flags;
  logic [FLAG_W-1:0] saved_flags;
  logic              capture;
  logic              restore;

  // Read mux: bypass of a same-cycle write wins over the flags alias,
  // which in turn wins over the stored register contents.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [AW-1:0]     rs,
    input logic [DATA_W-1:0] stored,
    input logic              wb,
    input logic [AW-1:0]     wa,
    input logic [DATA_W-1:0] wd,
    input logic [FLAG_W-1:0] fl
  );
    if ((BYPASS != 0) && wb && (wa == rs)) return wd;
    if (rs == FLAGS_A) return {{(DATA_W-FLAG_W){1'b0}}, fl};
    return stored;
  endfunction

  irq_ctx_fsm u_irq_ctx_fsm (
    .clk       (clk),
    .rst       (rst),
    .interrupt (bus.interrupt),
    .ret_i     (bus.ret_i),
    .capture   (capture),
    .restore   (restore),
    .irq_ack   (bus.irq_ack),
    .in_isr    (bus.in_isr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
    end else begin
      if (bus.isWb) regs[bus.rd_ra] <= bus.data;
      // EPC capture is the later assignment, so it overrides a same-cycle
      // writeback to EPC_IDX (that write is lost).
      if (capture) regs[EPC_A] <= bus.pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags       <= '0;
      saved_flags <= '0;
    end else begin
      if (capture) saved_flags <= flags;
      if (restore) flags <= saved_flags;
      else if (bus.isWb && (bus.rd_ra == FLAGS_A)) flags <= bus.data[FLAG_W-1:0];
      else if (bus.flags_we) flags <= bus.flags_in;
    end
  end

  always_comb begin
    bus.rd1 = read_port(bus.rs1, regs[bus.rs1], bus.isWb, bus.rd_ra, bus.data, flags);
    bus.rd2 = read_port(bus.rs2, regs[bus.rs2], bus.isWb, bus.rd_ra, bus.data, flags);
  end

  assign bus.flags_out = flags;

endmodule
